// File: rtl/multi_dma_wfifo_pkg.sv
// Shared types and helpers for the multi-channel DMA write FIFO.
// Entry layout and channel-index width derivation.
package multi_dma_pkg;

  localparam int ENTRY_DW = 32;

  typedef struct packed {
    logic                eof;
    logic [ENTRY_DW-1:0] data;
  } entry_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_dma_wfifo_if.sv
// Write-side and read-side handshake bundle of the DMA write FIFO.
// Master is the producer/DMA engine, slave is the FIFO.
interface multi_dma_wfifo_if #(
  parameter int DW = 32,
  parameter int CW = 1
) ();

  logic          in_val;
  logic [CW-1:0] in_ch;
  logic [DW-1:0] in_dat;
  logic          in_eof;
  logic          in_rdy;
  logic [CW-1:0] rd_ch;
  logic          dff_ack;
  logic [DW-1:0] rd_dat;
  logic          dff_eof;

  modport master (
    output in_val, in_ch, in_dat, in_eof,
    output rd_ch, dff_ack,
    input  in_rdy, rd_dat, dff_eof
  );

  modport slave (
    input  in_val, in_ch, in_dat, in_eof,
    input  rd_ch, dff_ack,
    output in_rdy, rd_dat, dff_eof
  );

endinterface

// File: rtl/multi_dma_wfifo_chptr.sv
// One channel's read/write pointers and fill count.
// Flush dominates push and pop on this channel.
module mdma_wfifo_chptr #(
  parameter int FW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [FW-1:0] wr_ptr,
  output logic [FW-1:0] rd_ptr,
  output logic [FW:0]   cnt,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  localparam logic [FW:0] DEPTH = {1'b1, {FW{1'b0}}};

  assign full  = (cnt == DEPTH);
  assign empty = (cnt == '0);
  // Push gating should make this unreachable; it flags a fault.
  assign ovf   = push & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/multi_dma_wfifo.sv
// Multi-channel show-ahead write FIFO feeding a DMA bus unit.
// Per-channel flop storage, registered fill levels, sticky errors.
module multi_dma_wfifo
  import multi_dma_pkg::*;
#(
  parameter int DW = 32,
  parameter int FW = 6,
  parameter int CH = 2,
  parameter int CW = clog2_min1(CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multi_dma_wfifo_if.slave     bus,
  input  logic [CH-1:0]        flush,
  output logic [CH-1:0][FW:0]  dff_cnt,
  output logic [1:0]           err
);

  localparam int DEPTH = 2 ** FW;

  typedef struct packed {
    logic          eof;
    logic [DW-1:0] data;
  } word_t;

  word_t mem [CH][DEPTH];

  logic [CH-1:0][FW-1:0] wr_ptr;
  logic [CH-1:0][FW-1:0] rd_ptr;
  logic [CH-1:0] wsel, rsel;
  logic [CH-1:0] full, empty;
  logic [CH-1:0] push, pop;
  logic [CH-1:0] ovf, udf;
  word_t         head;

  // Out-of-range channel indices match no channel and become no-ops.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign wsel[i] = (bus.in_ch == CW'(i));
    assign rsel[i] = (bus.rd_ch == CW'(i));
    assign push[i] = bus.in_val & wsel[i]
                   & ~full[i] & ~flush[i];
    assign pop[i]  = bus.dff_ack & rsel[i]
                   & ~empty[i] & ~flush[i];
    assign udf[i]  = bus.dff_ack & rsel[i] & empty[i];

    mdma_wfifo_chptr #(.FW(FW)) u_ptr (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push[i]),
      .pop    (pop[i]),
      .flush  (flush[i]),
      .wr_ptr (wr_ptr[i]),
      .rd_ptr (rd_ptr[i]),
      .cnt    (dff_cnt[i]),
      .full   (full[i]),
      .empty  (empty[i]),
      .ovf    (ovf[i])
    );
  end

  assign bus.in_rdy = |(wsel & ~full & ~flush);

  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {bus.in_eof, bus.in_dat};
      end
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < CH; i++) begin
      if (rsel[i]) head = mem[i][rd_ptr[i]];
    end
  end

  assign bus.rd_dat  = head.data;
  assign bus.dff_eof = head.eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= '0;
    end else begin
      err <= err | {|udf, |ovf};
    end
  end

endmodule

// File: tb/tb_multi_dma_wfifo.sv
// Self-checking bench: vector table plus queue scoreboard
// for the multi-channel DMA write FIFO.
module tb_multi_dma_wfifo;
  import multi_dma_pkg::*;

  localparam int DW = 32;
  localparam int FW = 6;
  localparam int CH = 2;
  localparam int CW = 1;
  localparam int DEPTH = 64;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CH-1:0]       flush;
  logic [CH-1:0][FW:0] dff_cnt;
  logic [1:0]          err;

  multi_dma_wfifo_if #(.DW(DW), .CW(CW)) bus ();

  multi_dma_wfifo #(
    .DW(DW), .FW(FW), .CH(CH), .CW(CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .flush   (flush),
    .dff_cnt (dff_cnt),
    .err     (err)
  );

  always #5 clk = ~clk;

  int        n_run = 0;
  int        n_fail = 0;
  entry_t    q0[$];
  entry_t    q1[$];
  logic [1:0] merr;

  typedef struct {
    logic        pv;
    logic        pch;
    logic [31:0] pd;
    logic        pe;
    logic        ack;
    logic        rch;
    logic [1:0]  fl;
    logic        rdy;
    logic [6:0]  c0;
    logic [6:0]  c1;
    logic [1:0]  er;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic int qsz(input logic ch);
    return ch ? q1.size() : q0.size();
  endfunction

  function automatic entry_t qhead(input logic ch);
    return ch ? q1[0] : q0[0];
  endfunction

  task automatic idle();
    bus.in_val  = 1'b0;
    bus.in_ch   = '0;
    bus.in_dat  = '0;
    bus.in_eof  = 1'b0;
    bus.dff_ack = 1'b0;
    bus.rd_ch   = '0;
    flush       = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #3;
    q0.delete();
    q1.delete();
    merr = 2'b00;
    chk("rst_async_cnt", 64'(dff_cnt), 64'd0);
    chk("rst_async_err", 64'(err), 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    chk("rst_cnt", 64'(dff_cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
  endtask

  // One clock: drive at edge+1, sample mid-cycle, update model at edge.
  task automatic cyc(input logic pv, input logic pch,
                     input logic [31:0] pd, input logic pe,
                     input logic ack, input logic rch,
                     input logic [1:0] fl,
                     output logic rdy_s);
    logic   exp_rdy, do_push, do_pop, do_udf;
    entry_t e, h;
    bus.in_val  = pv;
    bus.in_ch   = pch;
    bus.in_dat  = pd;
    bus.in_eof  = pe;
    bus.dff_ack = ack;
    bus.rd_ch   = rch;
    flush       = fl;
    #4;
    rdy_s   = bus.in_rdy;
    exp_rdy = (qsz(pch) != DEPTH) && !fl[pch];
    chk("in_rdy", 64'(rdy_s), 64'(exp_rdy));
    do_push = pv && exp_rdy;
    do_pop  = ack && !fl[rch] && (qsz(rch) != 0);
    do_udf  = ack && (qsz(rch) == 0);
    if (ack && qsz(rch) != 0) begin
      h = qhead(rch);
      chk("rd_dat", 64'(bus.rd_dat), 64'(h.data));
      chk("dff_eof", 64'(bus.dff_eof), 64'(h.eof));
    end
    @(posedge clk);
    if (do_pop) begin
      if (rch) void'(q1.pop_front());
      else     void'(q0.pop_front());
    end
    if (do_push) begin
      e.eof  = pe;
      e.data = pd;
      if (pch) q1.push_back(e);
      else     q0.push_back(e);
    end
    if (fl[0]) q0.delete();
    if (fl[1]) q1.delete();
    if (do_udf) merr[1] = 1'b1;
    #1;
    chk("dff_cnt0", 64'(dff_cnt[0]), 64'(q0.size()));
    chk("dff_cnt1", 64'(dff_cnt[1]), 64'(q1.size()));
    chk("err", 64'(err), 64'(merr));
  endtask

  initial begin
    logic r;
    rst_n = 1'b0;
    idle();
    merr = 2'b00;

    tbl[0] = '{1, 0, 32'hA0, 0, 0, 0, 2'b00,
               1, 7'd1, 7'd0, 2'b00};
    tbl[1] = '{1, 1, 32'hB0, 1, 0, 0, 2'b00,
               1, 7'd1, 7'd1, 2'b00};
    tbl[2] = '{1, 0, 32'hA1, 1, 1, 1, 2'b00,
               1, 7'd2, 7'd0, 2'b00};
    tbl[3] = '{0, 0, 32'h0, 0, 1, 0, 2'b00,
               1, 7'd1, 7'd0, 2'b00};
    tbl[4] = '{1, 1, 32'hB1, 0, 1, 0, 2'b00,
               1, 7'd0, 7'd1, 2'b00};
    tbl[5] = '{0, 0, 32'h0, 0, 1, 0, 2'b00,
               1, 7'd0, 7'd1, 2'b10};
    tbl[6] = '{1, 1, 32'hB2, 0, 0, 0, 2'b10,
               0, 7'd0, 7'd0, 2'b10};

    #1;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].pv, tbl[i].pch, tbl[i].pd, tbl[i].pe,
          tbl[i].ack, tbl[i].rch, tbl[i].fl, r);
      chk($sformatf("tbl%0d_rdy", i),
          64'(r), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_c0", i),
          64'(dff_cnt[0]), 64'(tbl[i].c0));
      chk($sformatf("tbl%0d_c1", i),
          64'(dff_cnt[1]), 64'(tbl[i].c1));
      chk($sformatf("tbl%0d_err", i),
          64'(err), 64'(tbl[i].er));
    end

    // 16 words into ch0, last one flagged eof, then drain.
    do_reset();
    for (int i = 0; i < 16; i++)
      cyc(1, 0, 32'h100 + i, i == 15, 0, 0, 2'b00, r);
    chk("seq16_cnt0", 64'(dff_cnt[0]), 64'd16);
    for (int i = 0; i < 16; i++)
      cyc(0, 0, 0, 0, 1, 0, 2'b00, r);
    chk("seq16_drained", 64'(dff_cnt[0]), 64'd0);

    // Fill ch1 completely; ch0 must stay writable.
    for (int i = 0; i < 64; i++)
      cyc(1, 1, 32'h400 + i, 0, 0, 0, 2'b00, r);
    chk("full_cnt1", 64'(dff_cnt[1]), 64'd64);
    cyc(1, 1, 32'hDEAD, 0, 0, 0, 2'b00, r);
    chk("full_rdy1", 64'(r), 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, r);
    chk("full_rdy0", 64'(r), 64'd1);
    chk("full_cnt1_hold", 64'(dff_cnt[1]), 64'd64);

    // Steady push+pop across the 63->0 pointer wrap.
    do_reset();
    for (int i = 0; i < 60; i++)
      cyc(1, 0, 32'h200 + i, 0, 0, 0, 2'b00, r);
    for (int i = 0; i < 55; i++)
      cyc(0, 0, 0, 0, 1, 0, 2'b00, r);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 32'h300 + i, i == 9, 1, 0, 2'b00, r);
      chk("wrap_cnt0", 64'(dff_cnt[0]), 64'd5);
    end
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 0, 1, 0, 2'b00, r);

    // Underflow on empty ch1 is sticky until reset.
    cyc(0, 0, 0, 0, 1, 1, 2'b00, r);
    chk("udf_err", 64'(err), 64'd2);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, r);
    chk("udf_sticky", 64'(err), 64'd2);
    do_reset();

    // Flush ch0 with a colliding push; ch1 untouched.
    for (int i = 0; i < 20; i++)
      cyc(1, 0, 32'h500 + i, 0, 0, 0, 2'b00, r);
    for (int i = 0; i < 8; i++)
      cyc(1, 1, 32'h600 + i, i == 7, 0, 0, 2'b00, r);
    cyc(1, 0, 32'hBEEF, 0, 0, 0, 2'b01, r);
    chk("flush_rdy", 64'(r), 64'd0);
    chk("flush_cnt0", 64'(dff_cnt[0]), 64'd0);
    chk("flush_cnt1", 64'(dff_cnt[1]), 64'd8);
    for (int i = 0; i < 8; i++)
      cyc(0, 0, 0, 0, 1, 1, 2'b00, r);
    cyc(1, 0, 32'h7A, 1, 0, 0, 2'b00, r);
    cyc(0, 0, 0, 0, 1, 0, 2'b00, r);

    // Reset mid-transfer discards buffered words.
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 32'h800 + i, 0, 0, 0, 2'b00, r);
    do_reset();
    cyc(1, 0, 32'h900, 1, 0, 0, 2'b00, r);
    cyc(0, 0, 0, 0, 1, 0, 2'b00, r);
    chk("post_rst_cnt0", 64'(dff_cnt[0]), 64'd0);
    chk("post_rst_err", 64'(err), 64'd0);

    idle();
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_dma_wfifo.md
MULTI_DMA_WFIFO -- requirements
Module: multi_dma_wfifo

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width in bits.
REQ-002 SHALL have parameter FW, default 6, meaning per-channel depth 2**FW words.
REQ-003 SHALL have parameter CH, default 2, meaning channel count (>=1).
REQ-004 SHALL have parameter CW, default $clog2(CH) (min 1), meaning channel index width.
REQ-005 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_val  input  1  write word valid.
REQ-008 SHALL have port in_ch  input  CW  target channel of write word.
REQ-009 SHALL have port in_dat  input  DW  write data.
REQ-010 SHALL have port in_eof  input  1  word is last of its transfer.
REQ-011 SHALL have port in_rdy  output  1  write accepted when in_val&in_rdy.
REQ-012 SHALL have port flush  input  CH  per-channel synchronous clear.
REQ-013 SHALL have port dff_cnt  output  CH x (FW+1)  per-channel fill level.
REQ-014 SHALL have port rd_ch  input  CW  channel selected for read (driven by DMA biu_ch).
REQ-015 SHALL have port dff_ack  input  1  pop one word from rd_ch.
REQ-016 SHALL have port rd_dat  output  DW  head word of rd_ch.
REQ-017 SHALL have port dff_eof  output  1  eof flag of head word of rd_ch.
REQ-018 SHALL have port err  output  2  sticky {underflow, overflow}.

Function
REQ-019 Storage SHALL be CH independent circular buffers of 2**FW entries, each entry DW+1 bits (data, eof), flop array, asynchronous read.
REQ-020 Each channel SHALL hold wr_ptr, rd_ptr (FW bits, wrap 2**FW-1 -> 0) and cnt (FW+1 bits, 0..2**FW).
REQ-021 in_rdy SHALL equal cnt[in_ch] != 2**FW and ~flush[in_ch], combinational.
REQ-022 Push (in_val&in_rdy) SHALL write entry wr_ptr[in_ch] and increment that wr_ptr at the clock edge.
REQ-023 rd_dat/dff_eof SHALL combinationally show entry rd_ptr[rd_ch] (show-ahead, zero latency); value undefined when cnt[rd_ch]==0.
REQ-024 Pop (dff_ack & cnt[rd_ch]!=0 & ~flush[rd_ch]) SHALL increment rd_ptr[rd_ch] at the clock edge.
REQ-025 dff_cnt SHALL be the registered cnt, updated the cycle after push/pop (1-cycle latency, DMA DELAY_CNT=0 compatible).
REQ-026 Push and pop same channel same cycle SHALL leave cnt unchanged; both pointers advance; legal even when full (pop frees before push is blocked? no: in_rdy uses current cnt, so full blocks push).
REQ-027 Push and pop on different channels same cycle SHALL update both channels independently.
REQ-028 Pop on empty SHALL be ignored and set err[1]; in_val with in_rdy low SHALL NOT set err[0] (backpressure is legal).
REQ-029 err[0] SHALL be set only if a push reaches a full channel by internal fault (cnt overflow detect); err bits clear only on reset.
REQ-030 flush[i] SHALL zero wr_ptr, rd_ptr, cnt of channel i next edge; flush wins over simultaneous push/pop on i.
REQ-031 in_ch or rd_ch >= CH SHALL be treated as no-op (no push, no pop, in_rdy=0).

Reset
REQ-032 rst_n low SHALL asynchronously clear all pointers, cnt, dff_cnt, err; in_rdy=1 after release (ch valid), rd_dat/dff_eof don't-care.
REQ-033 Storage array SHALL NOT be reset.
REQ-034 Reset asserted mid-transfer SHALL discard all buffered words; no partial state survives.

Structure
REQ-035 Shared package multi_dma_pkg SHALL hold typedef of entry struct {eof, data} and constant-free helper for CW=max(1,$clog2(CH)).
REQ-036 One sub-module mdma_wfifo_chptr SHALL implement a single channel's pointers/cnt/flush, instantiated CH times via generate.
REQ-037 Total RTL SHALL be single clock domain, no latches.

Verification (DW=32, FW=6, CH=2)
REQ-038 Reset, push 16 words 0x100..0x10F to ch0, last eof -> dff_cnt[0]=16 one cycle after last push; rd_ch=0, 16 pops return 0x100..0x10F, dff_eof=1 only on 0x10F.
REQ-039 Push 64 words to ch1 -> in_rdy=0 for in_ch=1 while in_rdy=1 for in_ch=0; dff_cnt[1]=64.
REQ-040 ch0 holding 5 words, push ch0 and pop ch0 same cycle for 10 cycles -> dff_cnt[0] stays 5, order preserved across pointer wrap at 63->0.
REQ-041 Pop with rd_ch=1 empty -> err=2'b10, dff_cnt unchanged; reset -> err=0.
REQ-042 ch0 holding 20 words, flush[0]=1 with simultaneous push to ch0 and 8 words in ch1 -> dff_cnt[0]=0, dff_cnt[1]=8, push dropped.
